// File: rtl/disp_pkg.sv
// Shared types and constants for the 74HC595 display shift driver.
package disp_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DIV_DEFAULT   = 4;
  localparam int DIV_W         = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } disp_state_t;

endpackage

// File: rtl/disp_tick_gen.sv
// Divider for the serial clock phases: one tick every DIV system clocks,
// held at its reload value while clear is high.
module disp_tick_gen
  import disp_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= RELOAD;
    end else if (clear || (div_cnt == '0)) begin
      div_cnt <= RELOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick = !clear && (div_cnt == '0);

endmodule

// File: rtl/disp_shift_driver.sv
// Serialises one WIDTH-bit frame MSB first into a 74HC595 chain, then pulses
// the storage latch. All sr_* outputs decode only from registered state.
module disp_shift_driver
  import disp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DIV   = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  disp_state_t      state;
  disp_state_t      state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             tick;
  logic             div_clear;
  logic             accept;
  logic             shift_en;

  assign accept    = in_valid && (state == IDLE);
  assign div_clear = (state == IDLE);

  disp_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt != '0) begin
            shift_en   = 1'b1;
            state_next = SHIFT_LO;
          end else begin
            state_next = LATCH;
          end
        end
      end
      LATCH: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift only on leaving SHIFT_HI so sr_data is stable across the sr_clk rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= in_data;
      bit_cnt <= CNT_W'(WIDTH - 1);
    end else if (shift_en) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign sr_clk   = (state == SHIFT_HI);
  assign sr_latch = (state == LATCH);
  assign sr_data  = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg[WIDTH-1];

endmodule

// File: tb/tb_disp_shift_driver.sv
// Randomised self-checking bench: a default-parameter driver plus a WIDTH=8,
// DIV=1 driver, each observed by a monitor that rebuilds the shifted frames.
module tb_disp_shift_driver;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int FW = 8;
  localparam int FD = 1;
  localparam int FRAME_CYC  = 2 * W * D + D;
  localparam int FFRAME_CYC = 2 * FW * FD + FD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, sr_clk, sr_data, sr_latch, busy;
  logic [FW-1:0] f_in_data = '0;
  logic          f_in_valid = 1'b0;
  logic          f_in_ready, f_sr_clk, f_sr_data, f_sr_latch, f_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_shift_driver #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sr_clk(sr_clk), .sr_data(sr_data),
    .sr_latch(sr_latch), .busy(busy)
  );

  disp_shift_driver #(.WIDTH(FW), .DIV(FD)) dut_fast (
    .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .sr_clk(f_sr_clk), .sr_data(f_sr_data),
    .sr_latch(f_sr_latch), .busy(f_busy)
  );

  // Monitor state: bits seen at each sr_clk rise, latch width, completed frames.
  logic         prev_clk, prev_latch;
  logic [W-1:0] cur_bits;
  int           cur_n, latch_w, latch_total, edges_total;
  logic [W-1:0] frames[$];
  int           frame_edges[$];
  int           frame_latch[$];

  logic          f_prev_clk, f_prev_latch;
  logic [FW-1:0] f_bits;
  int            f_n, f_lw;
  logic [FW-1:0] f_frames[$];
  int            f_edges[$];
  int            f_latch[$];

  initial begin
    latch_total = 0;
    edges_total = 0;
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      prev_clk = 1'b0; prev_latch = 1'b0; cur_bits = '0; cur_n = 0; latch_w = 0;
    end else begin
      if (sr_clk && !prev_clk) begin
        cur_bits = {cur_bits[W-2:0], sr_data};
        cur_n++;
        edges_total++;
      end
      if (sr_latch) begin
        latch_w++;
        latch_total++;
      end
      if (!sr_latch && prev_latch) begin
        frames.push_back(cur_bits);
        frame_edges.push_back(cur_n);
        frame_latch.push_back(latch_w);
        cur_n = 0; latch_w = 0;
      end
      prev_clk = sr_clk; prev_latch = sr_latch;
      checks++;
      if ((sr_clk && sr_latch) || (in_ready !== !busy)) begin
        errors++;
        $display("[TB] FAIL invariant: sr_clk=%b sr_latch=%b in_ready=%b busy=%b (required latch&clk=0, in_ready=!busy)",
                 sr_clk, sr_latch, in_ready, busy);
      end
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      f_prev_clk = 1'b0; f_prev_latch = 1'b0; f_bits = '0; f_n = 0; f_lw = 0;
    end else begin
      if (f_sr_clk && !f_prev_clk) begin
        f_bits = {f_bits[FW-2:0], f_sr_data};
        f_n++;
      end
      if (f_sr_latch) f_lw++;
      if (!f_sr_latch && f_prev_latch) begin
        f_frames.push_back(f_bits);
        f_edges.push_back(f_n);
        f_latch.push_back(f_lw);
        f_n = 0; f_lw = 0;
      end
      f_prev_clk = f_sr_clk; f_prev_latch = f_sr_latch;
      checks++;
      if ((f_sr_clk && f_sr_latch) || (f_in_ready !== !f_busy)) begin
        errors++;
        $display("[TB] FAIL fast_invariant: sr_clk=%b sr_latch=%b in_ready=%b busy=%b",
                 f_sr_clk, f_sr_latch, f_in_ready, f_busy);
      end
    end
  end

  task automatic start_frame(input logic [W-1:0] d);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge just after accept; returns clock edges until in_ready.
  task automatic wait_idle(output int lat);
    lat = 0;
    while (!in_ready && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_frame(input string name, input logic [W-1:0] exp_data);
    int guard = 0;
    logic [W-1:0] got;
    int e, lw;
    while (frames.size() == 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (frames.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_present: no latched frame seen, required %h", name, exp_data);
      return;
    end
    got = frames.pop_front();
    e   = frame_edges.pop_front();
    lw  = frame_latch.pop_front();
    checks += 3;
    if (got !== exp_data) begin
      errors++;
      $display("[TB] FAIL %s_data: got %h required %h", name, got, exp_data);
    end
    if (e !== W) begin
      errors++;
      $display("[TB] FAIL %s_edges: got %0d required %0d", name, e, W);
    end
    if (lw !== D) begin
      errors++;
      $display("[TB] FAIL %s_latch_width: got %0d required %0d", name, lw, D);
    end
  endtask

  task automatic check_latency(input string name, input int lat);
    checks++;
    if (lat !== FRAME_CYC) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d required %0d", name, lat, FRAME_CYC);
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [W-1:0] d;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, sr_clk, sr_data, sr_latch} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy/busy/clk/data/latch=%b required 10000",
               {in_ready, busy, sr_clk, sr_data, sr_latch});
    end
    d = W'($urandom);
    in_data  = d;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_accept: busy got %b required 1", busy);
    end
    wait_idle(lat);
    check_latency("reset_first", lat);
    check_frame("reset_first", d);
  endtask

  task automatic test_a5c3();
    int lat;
    start_frame(16'hA5C3);
    wait_idle(lat);
    check_latency("a5c3", lat);
    check_frame("a5c3", 16'hA5C3);
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = W'($urandom);
      start_frame(d);
      wait_idle(lat);
      check_latency("random", lat);
      check_frame("random", d);
    end
  endtask

  task automatic test_back_to_back();
    int lat, e0;
    @(negedge clk);
    e0 = edges_total;
    in_data  = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h8000;
    wait_idle(lat);
    check_latency("b2b_first", lat);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_immediate_accept: busy got %b required 1", busy);
    end
    wait_idle(lat);
    check_latency("b2b_second", lat);
    check_frame("b2b_first", 16'h0001);
    check_frame("b2b_second", 16'h8000);
    checks++;
    if (edges_total - e0 !== 2 * W) begin
      errors++;
      $display("[TB] FAIL b2b_total_edges: got %0d required %0d", edges_total - e0, 2 * W);
    end
  endtask

  task automatic test_data_change();
    int lat;
    start_frame(16'h0000);
    @(posedge clk);
    #1 in_data = 16'hFFFF;
    wait_idle(lat);
    check_latency("data_change", lat);
    check_frame("data_change", 16'h0000);
  endtask

  task automatic test_reset_midframe();
    int n = 0, guard = 0, lt0, lat;
    logic p = 1'b0;
    start_frame(W'($urandom));
    while (n < 6 && guard < 500) begin
      if (sr_clk && !p) n++;
      p = sr_clk;
      if (n < 6) @(negedge clk);
      guard++;
    end
    lt0 = latch_total;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sr_clk, sr_data, sr_latch, in_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midframe_async_reset: got clk/data/latch/rdy=%b required 0001",
               {sr_clk, sr_data, sr_latch, in_ready});
    end
    #12 rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (latch_total !== lt0 || frames.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midframe_no_latch: latch cycles got %0d frames %0d required 0 and 0",
               latch_total - lt0, frames.size());
    end
    start_frame(16'h1234);
    wait_idle(lat);
    check_latency("after_abort", lat);
    check_frame("after_abort", 16'h1234);
  endtask

  task automatic test_fast();
    int lat = 0, bad = 0;
    @(negedge clk);
    f_in_data  = 8'hFF;
    f_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_in_valid = 1'b0;
    while (!f_in_ready && lat < 200) begin
      if (lat < 2 * FW && f_sr_clk !== (lat % 2 == 1)) bad++;
      @(negedge clk);
      lat++;
    end
    checks += 2;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL fast_toggle: got %0d off-pattern cycles required 0", bad);
    end
    if (lat !== FFRAME_CYC) begin
      errors++;
      $display("[TB] FAIL fast_latency: got %0d required %0d", lat, FFRAME_CYC);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (f_frames.size() == 0) begin
      errors++;
      $display("[TB] FAIL fast_present: no frame seen required %h", 8'hFF);
    end else begin
      checks += 2;
      if (f_frames.pop_front() !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL fast_data: wrong frame required %h", 8'hFF);
      end
      if (f_edges.pop_front() !== FW || f_latch.pop_front() !== FD) begin
        errors++;
        $display("[TB] FAIL fast_edges_latch: edge or latch count wrong required %0d and %0d", FW, FD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5c3();
    test_random();
    test_back_to_back();
    test_data_change();
    test_reset_midframe();
    test_fast();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_shift_driver.md
DISP_SHIFT_DRIVER -- requirements
Module: disp_shift_driver

Interface
REQ-001 Parameter WIDTH, default 16: bits per display frame (segments plus digit selects).
REQ-002 Parameter DIV, default 4: system clocks per sr_clk half-period; legal range 1..255.
REQ-003 Port clk  input  1: single system clock; all flops clock on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port in_data  input  WIDTH: frame to display, sampled on accept.
REQ-006 Port in_valid  input  1: upstream frame available.
REQ-007 Port in_ready  output  1: driver can accept a frame.
REQ-008 Port sr_clk  output  1: shift clock to the external 74HC595 chain.
REQ-009 Port sr_data  output  1: serial data to the chain, MSB first.
REQ-010 Port sr_latch  output  1: storage-register latch pulse to the chain.
REQ-011 Port busy  output  1: high whenever state is not IDLE.

Function
REQ-012 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-013 Accept occurs on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal (state==IDLE).
- in_data is captured into an internal shift register.
- The FSM moves to SHIFT_LO.
- The bit counter loads WIDTH-1.
- The divider counter loads DIV-1.
REQ-014 A divider tick SHALL assert when the divider counter reaches 0; the counter then reloads DIV-1; the counter is held at DIV-1 in IDLE.
REQ-015 SHIFT_LO: sr_clk=0 and sr_data=shift register MSB; on tick, go to SHIFT_HI.
REQ-016 SHIFT_HI: sr_clk=1 and sr_data unchanged, so data is stable across the rising edge. On tick:
- If the bit counter is nonzero: shift left by one, decrement the counter, go to SHIFT_LO.
- Otherwise: go to LATCH.
REQ-017 LATCH: sr_clk=0, sr_data=0, sr_latch=1; on tick, go to IDLE.
REQ-018 sr_latch SHALL be 1 only in LATCH; sr_clk SHALL be 1 only in SHIFT_HI.
REQ-019 Frame duration from the accept edge to in_ready=1 SHALL be exactly 2*WIDTH*DIV+DIV cycles (132 at the defaults).
REQ-020 in_valid and in_data SHALL be ignored while not IDLE; a held in_valid is accepted on the first IDLE cycle, with no idle gap required between frames.
REQ-021 in_data changing after accept SHALL NOT affect the frame in flight.
REQ-022 DIV=1 SHALL produce a tick every cycle, so each phase lasts one cycle.
REQ-023 All outputs SHALL be registered or decoded only from registered state; there is no combinational path from in_* to sr_*.

Reset
REQ-024 While rst=1, outputs SHALL take these values immediately:
- state=IDLE, in_ready=1, busy=0
- sr_clk=0, sr_data=0, sr_latch=0
- shift register, bit counter and divider counter reset
REQ-025 Reset asserted mid-frame SHALL abort the frame with no latch pulse.
REQ-026 After rst deasserts, the first rising edge SHALL accept a frame if in_valid=1.

Structure
REQ-027 Shared package disp_pkg holds:
- the state enum type (IDLE, SHIFT_LO, SHIFT_HI, LATCH)
- default WIDTH/DIV constants
- DIV_W = 8
REQ-028 Sub-module disp_tick_gen holds the divider counter:
- inputs: clk, rst, clear
- output: tick
REQ-029 Everything else (FSM, shift register, bit counter) lives in disp_shift_driver.

Verification
REQ-030 Defaults; in_data=16'hA5C3 pulsed valid for one cycle:
- 16 sr_clk rising edges
- sr_data sampled at each edge reads 1010_0101_1100_0011
- one sr_latch pulse, 4 cycles wide
- in_ready returns high 132 cycles after accept
REQ-031 in_valid held high with frames 16'h0001 then 16'h8000:
- second frame accepted on the first IDLE cycle
- captures show 0001 then 8000
- no extra sr_clk edges between frames
REQ-032 DIV=1, WIDTH=8, in_data=8'hFF:
- sr_clk toggles every cycle
- 8 rising edges, latch 1 cycle wide
- in_ready high again 17 cycles after accept
REQ-033 rst pulsed during SHIFT_HI of bit 5:
- sr_clk, sr_data and sr_latch go to 0 asynchronously
- no latch pulse occurs
- next frame 16'h1234 is captured intact
REQ-034 in_data changed to 16'hFFFF one cycle after accepting 16'h0000: captured frame is all zeros.
REQ-035 Assertions:
- sr_latch and sr_clk are never high together
- in_ready == !busy at all times
